// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and defaults for the UART transmit scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester and transmitter signals of the UART scheduler.
// master = scheduler side, slave = requesters plus transmitter side.
interface uart_tx_scheduler_if
  import uart_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = DATA_W_DEF
);
  localparam int IDX_W = $clog2(NREQ);

  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_start;
  logic                   tx_busy;
  logic                   baud_tick;
  logic [IDX_W-1:0]       grant_id;
  logic                   sched_busy;

  modport master (
    input  req, req_data, tx_busy, baud_tick,
    output ack, tx_data, tx_start, grant_id, sched_busy
  );

  modport slave (
    output req, req_data, tx_busy, baud_tick,
    input  ack, tx_data, tx_start, grant_id, sched_busy
  );
endinterface

// File: rtl/uart_tx_scheduler_rr_picker.sv
// Combinational rotate-priority picker.
// The winner is the first set request at or after ptr, wrapping NREQ-1 -> 0.
module uart_rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  int k;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    k      = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!valid && req[k[IDX_W-1:0]]) begin
        valid  = 1'b1;
        winner = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NREQ byte sources.
// Optional inter-frame idle gap enabled by defining UART_SCHED_GAP_EN.
//   state     | meaning
//   IDLE      | arbitrate; grant, latch byte, pulse ack/tx_start on exit
//   LAUNCH    | ack and tx_start high for this single cycle
//   WAIT_BUSY | waiting for the transmitter to raise tx_busy
//   WAIT_DONE | frame in flight, waiting for tx_busy to fall
//   GAP       | counting GAP_TICKS baud ticks of idle line
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int GAP_TICKS = 2
) (
  input logic             clk,
  input logic             nrst,
  uart_tx_scheduler_if.master bus
);

  localparam int IDX_W = $clog2(NREQ);

  sched_state_t      state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  winner;
  logic              win_valid;
  logic [NREQ-1:0]   ack_q;
  logic [DATA_W-1:0] tx_data_q;
  logic              tx_start_q;
  logic [IDX_W-1:0]  grant_q;
  logic              busy_q;

`ifdef UART_SCHED_GAP_EN
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  logic [GAP_W-1:0] gap_cnt;
`else
  logic unused_baud_tick;
  localparam int unused_gap_ticks = GAP_TICKS;
  assign unused_baud_tick = bus.baud_tick;
`endif

  uart_rr_picker #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req    (bus.req),
    .ptr    (ptr),
    .valid  (win_valid),
    .winner (winner)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= IDLE;
      ptr        <= '0;
      ack_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
`ifdef UART_SCHED_GAP_EN
      gap_cnt    <= '0;
`endif
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            tx_data_q  <= bus.req_data[int'(winner)*DATA_W +: DATA_W];
            grant_q    <= winner;
            ack_q      <= NREQ'(1) << winner;
            tx_start_q <= 1'b1;
            ptr        <= (winner == IDX_W'(NREQ-1)) ? '0 : winner + 1'b1;
            busy_q     <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          // A fast transmitter may already be busy; skip WAIT_BUSY then.
          state <= bus.tx_busy ? WAIT_DONE : WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
`ifdef UART_SCHED_GAP_EN
            gap_cnt <= '0;
            state   <= GAP;
`else
            busy_q  <= 1'b0;
            state   <= IDLE;
`endif
          end
        end
`ifdef UART_SCHED_GAP_EN
        GAP: begin
          if (bus.baud_tick) begin
            if (gap_cnt == GAP_W'(GAP_TICKS-1)) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
`endif
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.grant_id   = grant_q;
  assign bus.sched_busy = busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (NREQ=4, DATA_W=8, GAP_TICKS=2).
module tb_uart_tx_scheduler;

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_errors;
  logic got;
  int   n_extra;

  uart_tx_scheduler_if #(.NREQ(4), .DATA_W(8)) bus ();

  uart_tx_scheduler #(
    .NREQ      (4),
    .DATA_W    (8),
    .GAP_TICKS (2)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_start();
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.tx_start === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("start_seen", {31'd0, got}, 32'd1);
  endtask

  // transmitter busy for n cycles, counting stray ack/tx_start pulses
  task automatic busy_frame(input int n);
    n_extra = 0;
    bus.tx_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) n_extra++;
    end
  endtask

  task automatic finish_frame();
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.baud_tick = 1'b1;
      tick();
      if (bus.sched_busy === 1'b0) break;
    end
    bus.baud_tick = 1'b0;
    chk("back_to_idle", {31'd0, bus.sched_busy}, 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    nrst          = 1'b0;
    bus.req       = 4'b0000;
    bus.req_data  = {8'h43, 8'h32, 8'h21, 8'hA5};
    bus.tx_busy   = 1'b0;
    bus.baud_tick = 1'b0;

    // reset state
    do_reset();
    chk("rst_ack",      {28'd0, bus.ack},        32'h0);
    chk("rst_tx_start", {31'd0, bus.tx_start},   32'h0);
    chk("rst_tx_data",  {24'd0, bus.tx_data},    32'h0);
    chk("rst_grant",    {30'd0, bus.grant_id},   32'h0);
    chk("rst_busy",     {31'd0, bus.sched_busy}, 32'h0);

    // 1: single request, one-cycle latency, data held through frame
    bus.req = 4'b0001;
    tick();
    chk("t1_ack",      {28'd0, bus.ack},        32'h1);
    chk("t1_start",    {31'd0, bus.tx_start},   32'h1);
    chk("t1_grant",    {30'd0, bus.grant_id},   32'h0);
    chk("t1_data",     {24'd0, bus.tx_data},    32'hA5);
    chk("t1_busy",     {31'd0, bus.sched_busy}, 32'h1);
    bus.req = 4'b0000;
    tick();
    chk("t1_ack_off",   {28'd0, bus.ack},      32'h0);
    chk("t1_start_off", {31'd0, bus.tx_start}, 32'h0);
    bus.req_data[7:0] = 8'h00;
    busy_frame(6);
    chk("t1_data_hold", {24'd0, bus.tx_data}, 32'hA5);
    chk("t1_no_extra",  n_extra,              32'd0);
    finish_frame();
    chk("t1_data_idle", {24'd0, bus.tx_data}, 32'hA5);
    bus.req_data[7:0] = 8'h10;

    // 2: all four requesting -> 0,1,2,3,0
    do_reset();
    bus.req = 4'b1111;
    begin
      int exp_id [5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_d [4] = '{8'h10, 8'h21, 8'h32, 8'h43};
      for (int f = 0; f < 5; f++) begin
        wait_start();
        chk($sformatf("t2_grant%0d", f), {30'd0, bus.grant_id}, exp_id[f]);
        chk($sformatf("t2_ack%0d", f), {28'd0, bus.ack}, 32'd1 << exp_id[f]);
        chk($sformatf("t2_data%0d", f), {24'd0, bus.tx_data}, {24'd0, exp_d[exp_id[f]]});
        busy_frame(10);
        chk($sformatf("t2_once%0d", f), n_extra, 32'd0);
        finish_frame();
      end
    end
    bus.req = 4'b0000;

    // 3: ptr at 3 with req 1001 -> grant 3 then wrap to 0
    do_reset();
    bus.req = 4'b0100;
    wait_start();
    chk("t3_pre_grant", {30'd0, bus.grant_id}, 32'd2);
    bus.req = 4'b0000;
    busy_frame(4);
    finish_frame();
    bus.req = 4'b1001;
    wait_start();
    chk("t3_grant3", {30'd0, bus.grant_id}, 32'd3);
    chk("t3_ack3",   {28'd0, bus.ack},      32'h8);
    bus.req = 4'b0001;
    busy_frame(4);
    finish_frame();
    wait_start();
    chk("t3_grant0", {30'd0, bus.grant_id}, 32'd0);
    chk("t3_ack0",   {28'd0, bus.ack},      32'h1);
    bus.req = 4'b0000;
    busy_frame(4);
    finish_frame();

    // 4: reset during WAIT_DONE aborts; first grant afterwards is source 0
    do_reset();
    bus.req = 4'b1111;
    wait_start();
    busy_frame(3);
    nrst = 1'b0;
    tick();
    chk("t4_ack",   {28'd0, bus.ack},        32'h0);
    chk("t4_start", {31'd0, bus.tx_start},   32'h0);
    chk("t4_data",  {24'd0, bus.tx_data},    32'h0);
    chk("t4_grant", {30'd0, bus.grant_id},   32'h0);
    chk("t4_busy",  {31'd0, bus.sched_busy}, 32'h0);
    tick();
    chk("t4_start_hold", {31'd0, bus.tx_start}, 32'h0);
    bus.tx_busy = 1'b0;
    nrst = 1'b1;
    wait_start();
    chk("t4_first_grant", {30'd0, bus.grant_id}, 32'd0);
    bus.req = 4'b0000;
    busy_frame(3);
    finish_frame();

    // 5: spacing after tx_busy falls
    do_reset();
    bus.req = 4'b0001;
    wait_start();
    bus.req = 4'b0000;
    busy_frame(3);
    bus.req = 4'b0001;
    bus.tx_busy = 1'b0;
    tick();
    chk("t5_start_e1", {31'd0, bus.tx_start}, 32'h0);
`ifdef UART_SCHED_GAP_EN
    chk("t5_gap_busy", {31'd0, bus.sched_busy}, 32'h1);
    tick();
    tick();
    tick();
    chk("t5_no_tick_wait", {31'd0, bus.tx_start}, 32'h0);
    bus.baud_tick = 1'b1;
    tick();
    bus.baud_tick = 1'b0;
    tick();
    chk("t5_one_tick", {31'd0, bus.tx_start}, 32'h0);
    bus.baud_tick = 1'b1;
    tick();
    bus.baud_tick = 1'b0;
    chk("t5_gap_done", {31'd0, bus.sched_busy}, 32'h0);
    chk("t5_start_e2", {31'd0, bus.tx_start},   32'h0);
    tick();
    chk("t5_start_after_gap", {31'd0, bus.tx_start}, 32'h1);
`else
    chk("t5_idle", {31'd0, bus.sched_busy}, 32'h0);
    tick();
    chk("t5_start_e2", {31'd0, bus.tx_start}, 32'h1);
`endif
    bus.req = 4'b0000;
    busy_frame(3);
    finish_frame();

    // 6: request during WAIT_DONE waits for IDLE
    do_reset();
    bus.req_data[15:8] = 8'h5C;
    bus.req = 4'b0001;
    wait_start();
    bus.req = 4'b0000;
    busy_frame(2);
    bus.req = 4'b0010;
    busy_frame(3);
    chk("t6_no_ack_busy", n_extra,              32'd0);
    chk("t6_data_kept",   {24'd0, bus.tx_data}, 32'h10);
    finish_frame();
    wait_start();
    chk("t6_ack1",   {28'd0, bus.ack},      32'h2);
    chk("t6_grant1", {30'd0, bus.grant_id}, 32'd1);
    chk("t6_data1",  {24'd0, bus.tx_data},  32'h5C);
    bus.req = 4'b0000;
    busy_frame(3);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
